// File: rtl/aud_recorder_rx.sv
// I2S ADC receiver: captures left-channel samples from the codec and emits
// one sequential SRAM write request per sample, with pause/stop/auto-full control.
module aud_recorder_rx #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lrc,
  input  logic              i_data,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_len,
  output logic              o_full,
  output logic [1:0]        o_state
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SHIFT, S_WRITE, S_PAUSE} state_t;

  state_t            r_state, w_next;
  logic              r_lrc_d, r_pend, r_valid, r_full;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shift, r_data;
  logic [ADDR_W-1:0] r_addr, r_len;
  logic              w_lfs, w_last, w_at_max;
  logic [1:0]        w_state_code;

  // LRCK falling edge is the I2S delay slot; the MSB arrives on the next edge.
  assign w_lfs    = r_lrc_d & ~i_lrc;
  assign w_last   = (r_cnt == LAST_BIT);
  assign w_at_max = (r_addr == MAX_ADDR);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start && !i_stop) w_next = S_WAIT;
      S_WAIT: begin
        if      (i_stop)  w_next = S_IDLE;
        else if (i_pause) w_next = S_PAUSE;
        else if (w_lfs)   w_next = S_SHIFT;
      end
      S_SHIFT: begin
        if      (i_stop)  w_next = S_IDLE;
        else if (w_last)  w_next = S_WRITE;
      end
      // The strobe is already out, so the write finishes even on stop.
      S_WRITE: begin
        if      (w_at_max || i_stop) w_next = S_IDLE;
        else if (r_pend || i_pause)  w_next = S_PAUSE;
        else                         w_next = S_WAIT;
      end
      S_PAUSE: begin
        if      (i_stop)              w_next = S_IDLE;
        else if (i_start && !i_pause) w_next = S_WAIT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_state_code = 2'd0;
    case (r_state)
      S_WAIT, S_SHIFT, S_WRITE: w_state_code = 2'd1;
      S_PAUSE:                  w_state_code = 2'd2;
      default:                  w_state_code = 2'd0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lrc_d <= 1'b1;
      r_pend  <= 1'b0;
      r_valid <= 1'b0;
      r_full  <= 1'b0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_addr  <= '0;
      r_len   <= '0;
    end else begin
      r_lrc_d <= i_lrc;
      r_valid <= (r_state == S_SHIFT) && (w_next == S_WRITE);
      if (w_next == S_IDLE || w_next == S_PAUSE)
        r_pend <= 1'b0;
      else if (i_pause && (r_state == S_SHIFT || r_state == S_WRITE))
        r_pend <= 1'b1;
      case (r_state)
        S_IDLE: if (w_next == S_WAIT) begin
          r_addr <= '0;
          r_len  <= '0;
          r_full <= 1'b0;
        end
        S_WAIT: if (w_next == S_SHIFT) r_cnt <= '0;
        S_SHIFT: begin
          r_shift <= {r_shift[DATA_W-2:0], i_data};
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_next == S_WRITE) r_data <= {r_shift[DATA_W-2:0], i_data};
        end
        S_WRITE: begin
          r_len <= r_addr + ADDR_W'(1);
          if (w_at_max) r_full <= 1'b1;
          else          r_addr <= r_addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_address = r_addr;
  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_len     = r_len;
  assign o_full    = r_full;
  assign o_state   = w_state_code;

endmodule

// File: tb/tb_aud_recorder_rx.sv
// Directed bench for aud_recorder_rx: I2S frames driven bit by bit, strobes
// collected by a monitor and compared against hand-computed expectations.
module tb_aud_recorder_rx;
  localparam int DW = 16;
  localparam int AW = 20;
  localparam int HALF = 20;

  typedef struct {
    logic [DW-1:0] left;
    logic [DW-1:0] right;
    logic [AW-1:0] exp_addr;
    logic [AW-1:0] exp_len;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0, lrc = 1'b1, sdat = 1'b0;
  logic start = 1'b0, pause = 1'b0, stop = 1'b0;
  logic [AW-1:0] a_addr, a_len, f_addr, f_len;
  logic [DW-1:0] a_data, f_data;
  logic a_valid, f_valid, a_full, f_full;
  logic [1:0] a_state, f_state;

  aud_recorder_rx #(.DATA_W(DW), .ADDR_W(AW)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_lrc(lrc), .i_data(sdat),
    .i_start(start), .i_pause(pause), .i_stop(stop),
    .o_address(a_addr), .o_data(a_data), .o_valid(a_valid),
    .o_len(a_len), .o_full(a_full), .o_state(a_state));

  aud_recorder_rx #(.DATA_W(DW), .ADDR_W(AW), .MAX_ADDR(20'd3)) u_full (
    .i_clk(clk), .i_rst_n(rst_n), .i_lrc(lrc), .i_data(sdat),
    .i_start(start), .i_pause(pause), .i_stop(stop),
    .o_address(f_addr), .o_data(f_data), .o_valid(f_valid),
    .o_len(f_len), .o_full(f_full), .o_state(f_state));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, edge_cnt = 0, e0 = 0;
  logic [AW-1:0] wq_addr[$];
  logic [DW-1:0] wq_data[$];
  int            wq_edge[$];
  logic [AW-1:0] fq_addr[$];

  always @(posedge clk) edge_cnt++;

  always @(negedge clk) begin
    if (a_valid) begin
      wq_addr.push_back(a_addr);
      wq_data.push_back(a_data);
      wq_edge.push_back(edge_cnt);
    end
    if (f_valid) fq_addr.push_back(f_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic l, input logic d, input logic s, input logic p, input logic t);
    @(negedge clk);
    lrc = l; sdat = d; start = s; pause = p; stop = t;
  endtask

  task automatic pulse(input logic s, input logic p, input logic t);
    cyc(1'b1, 1'b0, s, p, t);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; lrc = 1'b1; sdat = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ctl: 0 none, 1 pause, 2 stop, applied during left-half cycle ctl_cyc
  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                            input int ctl_cyc, input int ctl);
    for (int k = 0; k < HALF; k++) begin
      cyc(1'b0, (k >= 1 && k <= DW) ? l[DW-k] : 1'b0, 1'b0,
          (k == ctl_cyc && ctl == 1), (k == ctl_cyc && ctl == 2));
      if (k == 0) e0 = edge_cnt + 1;
    end
    for (int k = 0; k < HALF; k++)
      cyc(1'b1, (k >= 1 && k <= DW) ? r[DW-k] : 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    vec_t vt[4];
    int base;
    vt[0] = '{16'h0001, 16'hBEEF, 20'd0, 20'd1};
    vt[1] = '{16'h0002, 16'hFFFF, 20'd1, 20'd2};
    vt[2] = '{16'h0003, 16'h8000, 20'd2, 20'd3};
    vt[3] = '{16'h0004, 16'h7FFF, 20'd3, 20'd4};

    // reset values
    #12;
    chk("rst_addr", a_addr, 0);  chk("rst_data", a_data, 0);
    chk("rst_valid", a_valid, 0); chk("rst_len", a_len, 0);
    chk("rst_full", a_full, 0);  chk("rst_state", a_state, 0);
    @(negedge clk); rst_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // single capture with latency
    pulse(1'b1, 1'b0, 1'b0);
    chk("single_state", a_state, 1);
    base = wq_addr.size();
    send_frame(16'hA5C3, 16'hFFFF, -1, 0);
    chk("single_count", wq_addr.size() - base, 1);
    if (wq_addr.size() > base) begin
      chk("single_data", wq_data[base], 16'hA5C3);
      chk("single_addr", wq_addr[base], 0);
      chk("single_latency", wq_edge[base] - e0, DW);
    end
    chk("single_len", a_len, 1);
    chk("single_addr_after", a_addr, 1);

    // continuous capture, table driven
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    base = wq_addr.size();
    for (int i = 0; i < 4; i++) begin
      send_frame(vt[i].left, vt[i].right, -1, 0);
      chk($sformatf("cont%0d_count", i), wq_addr.size() - base, i + 1);
      if (wq_addr.size() > base + i) begin
        chk($sformatf("cont%0d_addr", i), wq_addr[base+i], vt[i].exp_addr);
        chk($sformatf("cont%0d_data", i), wq_data[base+i], vt[i].left);
      end
      chk($sformatf("cont%0d_len", i), a_len, vt[i].exp_len);
    end

    // pause mid-sample 2, resume later
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    base = wq_addr.size();
    send_frame(16'h1111, 16'h0, -1, 0);
    send_frame(16'h2222, 16'h0, -1, 0);
    send_frame(16'h3333, 16'h0, 8, 1);
    chk("pause_count", wq_addr.size() - base, 3);
    if (wq_addr.size() > base + 2) begin
      chk("pause_s2_addr", wq_addr[base+2], 2);
      chk("pause_s2_data", wq_data[base+2], 16'h3333);
    end
    chk("pause_state", a_state, 2);
    for (int i = 0; i < 3; i++) send_frame(16'hDEAD, 16'h0, -1, 0);
    chk("pause_idle_count", wq_addr.size() - base, 3);
    chk("pause_addr_held", a_addr, 3);
    pulse(1'b1, 1'b0, 1'b0);
    chk("resume_state", a_state, 1);
    send_frame(16'h4444, 16'h0, -1, 0);
    chk("resume_count", wq_addr.size() - base, 4);
    if (wq_addr.size() > base + 3) begin
      chk("resume_addr", wq_addr[base+3], 3);
      chk("resume_data", wq_data[base+3], 16'h4444);
    end
    chk("resume_len", a_len, 4);

    // stop mid-sample
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    base = wq_addr.size();
    send_frame(16'h1234, 16'h0, -1, 0);
    send_frame(16'h5678, 16'h0, 8, 2);
    chk("stop_count", wq_addr.size() - base, 1);
    chk("stop_state", a_state, 0);
    chk("stop_len", a_len, 1);
    chk("stop_addr", a_addr, 1);
    pulse(1'b1, 1'b0, 1'b0);
    chk("restart_len", a_len, 0);
    chk("restart_addr", a_addr, 0);
    send_frame(16'h9ABC, 16'h0, -1, 0);
    chk("restart_count", wq_addr.size() - base, 2);
    if (wq_addr.size() > base + 1) begin
      chk("restart_waddr", wq_addr[base+1], 0);
      chk("restart_data", wq_data[base+1], 16'h9ABC);
    end
    chk("restart_len_after", a_len, 1);

    // auto-stop at MAX_ADDR = 3
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    base = fq_addr.size();
    for (int i = 0; i < 5; i++) begin
      send_frame(16'(i + 1), 16'h0, -1, 0);
      if (i == 2) chk("full_early", f_full, 0);
    end
    chk("full_count", fq_addr.size() - base, 4);
    for (int j = 0; j < 4; j++)
      if (fq_addr.size() > base + j) chk($sformatf("full_addr%0d", j), fq_addr[base+j], j);
    chk("full_flag", f_full, 1);
    chk("full_state", f_state, 0);
    chk("full_len", f_len, 4);
    chk("full_addr_held", f_addr, 3);
    chk("nofull_big", a_full, 0);

    // async reset mid-shift
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    send_frame(16'hCAFE, 16'h0, -1, 0);
    base = wq_addr.size();
    for (int k = 0; k < 8; k++) cyc(1'b0, k[0], 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_addr", a_addr, 0);  chk("arst_data", a_data, 0);
    chk("arst_valid", a_valid, 0); chk("arst_len", a_len, 0);
    chk("arst_full", a_full, 0);  chk("arst_state", a_state, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 12; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < HALF; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(16'h0F0F, 16'h0, -1, 0);
    chk("arst_no_write", wq_addr.size() - base, 0);
    chk("arst_state_idle", a_state, 0);

    // pause from WAIT, then stop+start together in PAUSE
    pulse(1'b1, 1'b0, 1'b0);
    send_frame(16'h5555, 16'h0, -1, 0);
    pulse(1'b0, 1'b1, 1'b0);
    chk("wait_pause_state", a_state, 2);
    pulse(1'b1, 1'b0, 1'b1);
    chk("stop_wins_state", a_state, 0);
    chk("stop_wins_addr", a_addr, 1);
    chk("stop_wins_len", a_len, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
